aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Iterative AES encryption round sequencer: accepts one 128-bit plaintext block, runs NR rounds through an external round-transform datapath, returns the ciphertext.
- Datapath contract: SubBytes -> ShiftRows -> MixColumns, with MixColumns skipped when o_dp_final=1. The datapath does not add the key.
- This block performs all AddRoundKey XORs itself, fetches round keys by index from the key store, and runs valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- DP_LAT, 0, datapath latency in cycles from o_dp_start to valid i_dp_result (0..3; 0 = combinational).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input block valid.
- o_ready  out  1  block can accept input (IDLE only).
- i_block  in  128  plaintext, word0 in [127:96], byte0 in [127:120].
- o_rk_idx  out  4  round-key index to key store.
- i_rk  in  128  round key for o_rk_idx, combinational, valid in the same cycle.
- o_dp_start  out  1  one-cycle pulse launching a round.
- o_dp_state  out  128  state presented to datapath (state register).
- o_dp_final  out  1  final round, datapath skips MixColumns.
- i_dp_result  in  128  datapath output (without key).
- o_valid  out  1  ciphertext valid.
- i_ready  in  1  downstream accepts ciphertext.
- o_block  out  128  ciphertext (state register).
- o_busy  out  1  state != IDLE.
- o_round  out  4  current round counter.

Behaviour:
- State register st[127:0], round counter rnd[3:0], latency counter lat[1:0], FSM {IDLE, ISSUE, WAIT, OUT}.
- Reset, asynchronous and immediate: FSM=IDLE; st, rnd, lat = 0.
  - Outputs in reset: o_valid=0, o_dp_start=0, o_dp_final=0, o_rk_idx=0, o_block=0, o_busy=0, o_round=0.
  - o_ready=1 once reset is deasserted.
- IDLE:
  - o_ready=1, o_rk_idx=0.
  - On i_valid: st <= i_block ^ i_rk (initial whitening with key 0), rnd <= 1, go to ISSUE.
- ISSUE:
  - o_dp_start=1, o_rk_idx=rnd, o_dp_final=(rnd==NR), lat <= 0.
  - DP_LAT=0: capture in the same cycle (see capture rule); otherwise go to WAIT.
- WAIT:
  - o_rk_idx=rnd; o_dp_final stays asserted for the final round; lat increments each cycle.
  - Capture occurs in the cycle where lat == DP_LAT-1 (i.e. DP_LAT cycles after ISSUE).
- Capture rule: st <= i_dp_result ^ i_rk.
  - If rnd==NR, go to OUT.
  - Else rnd <= rnd+1 and go to ISSUE.
- o_dp_state = st throughout; the datapath samples it at o_dp_start.
- OUT:
  - o_valid=1, o_rk_idx=NR; o_block and o_round hold stable until i_ready.
  - On i_valid_out & i_ready handshake, go to IDLE.
  - No new input is accepted in the handshake cycle; o_ready first rises the next cycle.
- Latency:
  - Input handshake in cycle 0; o_valid first high in cycle 1 + NR*(DP_LAT+1).
  - Example: cycle 11 for NR=10, DP_LAT=0.
  - Throughput: one block per 2 + NR*(DP_LAT+1) cycles when i_ready is held high.
- Per block: exactly NR o_dp_start pulses; o_dp_final asserted for exactly one round (rnd==NR).
- i_valid while o_ready=0 is ignored; no input buffering.
- i_ready while o_valid=0 has no effect.
- i_rst asserted mid-run: the block is abandoned; no o_valid for it; all outputs return to reset values in the same cycle.
- Width rules:
  - All XORs are 128-bit bitwise.
  - rnd never exceeds NR and never wraps; NR must be <= 14.

Test Plan:
- FIPS-197 C.1, NR=10, DP_LAT=0, golden round model, key-store model with expanded key 000102…0f: i_block=00112233445566778899aabbccddeeff -> o_valid in cycle 11, o_block=69c4e0d86a7b0430d8cdb78070b4c55a.
- Same vector with DP_LAT=2 -> o_valid in cycle 31, same ciphertext; 10 o_dp_start pulses each 3 cycles apart; o_dp_final high only in the last round.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_block stable, o_ready=0, i_valid ignored; on i_ready=1 -> next cycle o_ready=1.
- Back-to-back: two vectors with i_valid held high and i_ready=1 -> second accepted exactly 1 cycle after the first output handshake; both ciphertexts correct.
- Reset mid-run: assert i_rst while o_round=5 -> o_busy=0, o_dp_start=0, o_round=0 immediately; after release, a new block yields the correct ciphertext.
- Key-sequence check: record o_rk_idx at each capture -> 0,1,…,10 in order; o_rk_idx=10 during OUT.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer.
// Holds the cipher state, performs every AddRoundKey XOR locally, steps the
// round-key index through the external key store, and launches one round per
// trip through ISSUE on an external SubBytes/ShiftRows/MixColumns datapath
// whose latency is DP_LAT cycles (0 = combinational).
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_block,
    output logic [3:0]   o_rk_idx,
    input  logic [127:0] i_rk,
    output logic         o_dp_start,
    output logic [127:0] o_dp_state,
    output logic         o_dp_final,
    input  logic [127:0] i_dp_result,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_block,
    output logic         o_busy,
    output logic [3:0]   o_round
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] NR_C     = 4'(NR);
    // Latency counter value in the cycle the datapath result is valid.
    localparam logic [1:0] LAT_LAST = (DP_LAT > 0) ? 2'(DP_LAT - 1) : 2'd0;

    state_t         state_q, state_d;
    logic [127:0]   st_q, st_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [1:0]     lat_q, lat_d;

    logic [3:0]     rk_idx_s;
    logic           dp_start_s;
    logic           dp_final_s;
    logic [127:0]   cap_st_s;
    logic           last_s;

    // Round result with its key mixed in, and whether this is the last round.
    always_comb begin
        cap_st_s = i_dp_result ^ i_rk;
        last_s   = (rnd_q == NR_C);
    end

    // Next-state, datapath-control and key-index decode.
    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        rnd_d      = rnd_q;
        lat_d      = lat_q;
        rk_idx_s   = 4'd0;
        dp_start_s = 1'b0;
        dp_final_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rk_idx_s = 4'd0;
                if (i_valid) begin
                    // Initial whitening with round key 0.
                    st_d    = i_block ^ i_rk;
                    rnd_d   = 4'd1;
                    lat_d   = 2'd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                dp_start_s = 1'b1;
                rk_idx_s   = rnd_q;
                dp_final_s = last_s;
                lat_d      = 2'd0;
                if (DP_LAT == 0) begin
                    // Combinational datapath: result is ready this cycle.
                    st_d = cap_st_s;
                    if (last_s) begin
                        state_d = ST_OUT;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                rk_idx_s   = rnd_q;
                dp_final_s = last_s;
                if (lat_q == LAT_LAST) begin
                    st_d = cap_st_s;
                    if (last_s) begin
                        state_d = ST_OUT;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    lat_d   = lat_q + 2'd1;
                    state_d = ST_WAIT;
                end
            end

            ST_OUT: begin
                rk_idx_s = NR_C;
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, cipher-state, round and latency registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            st_q    <= 128'd0;
            rnd_q   <= 4'd0;
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            lat_q   <= lat_d;
        end
    end

    assign o_ready    = (state_q == ST_IDLE) & ~i_rst;
    assign o_rk_idx   = rk_idx_s;
    assign o_dp_start = dp_start_s;
    assign o_dp_final = dp_final_s;
    assign o_dp_state = st_q;
    assign o_valid    = (state_q == ST_OUT);
    assign o_block    = st_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_round    = rnd_q;

endmodule
